// File: rtl/gpio_input_conditioner.sv
// GPIO pad input conditioner: synchroniser, optional debounce, edge detect and W1C pending flags.
// Debounce counters exist only when GPIO_IN_DEBOUNCE_EN is defined; otherwise gpio_idr_o tracks sync directly.
module gpio_input_conditioner #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] pend_clr_i,
  output logic [WIDTH-1:0] gpio_idr_o,
  output logic [WIDTH-1:0] edge_pend_o,
  output logic             irq_o
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("gpio_input_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] idr_next;
  logic [WIDTH-1:0] pend_next;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt      [WIDTH];
  logic [CW-1:0] cnt_next [WIDTH];

  // A pin's new level is accepted only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    idr_next = gpio_idr_o;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
      if (sync[i] == gpio_idr_o[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        idr_next[i] = sync[i];
        cnt_next[i] = '0;
      end else begin
        cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end
`else
  assign idr_next = sync;
`endif

  // Edges are judged on the accepted level, so set happens on the same edge gpio_idr_o moves.
  assign rise_evt  = idr_next & ~gpio_idr_o & rise_en_i;
  assign fall_evt  = ~idr_next & gpio_idr_o & fall_en_i;
  assign pend_next = (edge_pend_o & ~pend_clr_i) | rise_evt | fall_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_idr_o  <= '0;
      edge_pend_o <= '0;
    end else begin
      gpio_idr_o  <= idr_next;
      edge_pend_o <= pend_next;
    end
  end

  assign irq_o = |edge_pend_o;

endmodule
